// File: rtl/fp_operand_align.sv
// FP add/sub operand alignment: orders a pair of IEEE singles by magnitude and
// shifts the smaller mantissa into the larger exponent frame with guard/round/sticky.
// Optional exp=255 short-circuit with special/is_nan outputs: define FP_SPECIAL_DETECT_EN.
module fp_operand_align #(
    parameter int SHIFT_PER_CYCLE = 1,
    parameter int MAX_SHIFT       = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_out,
    output logic [26:0] big_mant,
    output logic [26:0] small_mant,
    output logic        big_sign,
    output logic        small_sign,
    output logic        eff_sub,
`ifdef FP_SPECIAL_DETECT_EN
    output logic        special,
    output logic        is_nan,
`endif
    output logic        swapped
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [4:0] SPC  = 5'(SHIFT_PER_CYCLE);
    localparam logic [7:0] MAXS = 8'(MAX_SHIFT);

    state_t      state_q, state_d;
    logic [7:0]  exp_q, exp_d;
    logic [26:0] bm_q, bm_d, sm_q, sm_d;
    logic        bs_q, bs_d, ss_q, ss_d, sw_q, sw_d;
    logic [4:0]  cnt_q, cnt_d;

    // Accept-time decode of the incoming pair
    logic        swap_w;
    logic [31:0] big_w, sml_w;
    logic [7:0]  eb_w, es_w, diff_w;
    logic [4:0]  cnt_w;

    assign swap_w = src2[30:0] > src1[30:0];
    assign big_w  = swap_w ? src2 : src1;
    assign sml_w  = swap_w ? src1 : src2;
    assign eb_w   = (big_w[30:23] == 8'd0) ? 8'd1 : big_w[30:23];
    assign es_w   = (sml_w[30:23] == 8'd0) ? 8'd1 : sml_w[30:23];
    assign diff_w = eb_w - es_w;
    assign cnt_w  = (diff_w > MAXS) ? MAXS[4:0] : diff_w[4:0];

    // One shift step; everything pushed below bit 0 folds into the sticky bit
    logic [4:0]  step_w;
    logic [26:0] shifted_w;
    logic [27:0] mask_w;
    logic        lost_w;

    assign step_w    = (cnt_q < SPC) ? cnt_q : SPC;
    assign shifted_w = sm_q >> step_w;
    assign mask_w    = (28'd1 << step_w) - 28'd1;
    assign lost_w    = |(sm_q & mask_w[26:0]);

`ifdef FP_SPECIAL_DETECT_EN
    logic sp_q, sp_d, nan_q, nan_d;
    logic inf1_w, inf2_w, spec_w, nan_w;

    assign inf1_w = (&src1[30:23]) && (src1[22:0] == 23'd0);
    assign inf2_w = (&src2[30:23]) && (src2[22:0] == 23'd0);
    assign spec_w = (&src1[30:23]) || (&src2[30:23]);
    assign nan_w  = ((&src1[30:23]) && (src1[22:0] != 23'd0))
                 || ((&src2[30:23]) && (src2[22:0] != 23'd0))
                 || (inf1_w && inf2_w && (src1[31] ^ src2[31]));
`endif

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        bm_d    = bm_q;
        sm_d    = sm_q;
        bs_d    = bs_q;
        ss_d    = ss_q;
        sw_d    = sw_q;
        cnt_d   = cnt_q;
`ifdef FP_SPECIAL_DETECT_EN
        sp_d    = sp_q;
        nan_d   = nan_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_d   = eb_w;
                    bm_d    = {big_w[30:23] != 8'd0, big_w[22:0], 3'b000};
                    sm_d    = {sml_w[30:23] != 8'd0, sml_w[22:0], 3'b000};
                    bs_d    = big_w[31];
                    ss_d    = sml_w[31];
                    sw_d    = swap_w;
                    cnt_d   = cnt_w;
                    state_d = (cnt_w != 5'd0) ? SHIFT : DONE;
`ifdef FP_SPECIAL_DETECT_EN
                    sp_d    = spec_w;
                    nan_d   = nan_w;
                    if (spec_w) begin
                        sm_d    = '0;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            SHIFT: begin
                sm_d  = {shifted_w[26:1], shifted_w[0] | lost_w};
                cnt_d = cnt_q - step_w;
                if (cnt_q == step_w) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= '0;
            bm_q    <= '0;
            sm_q    <= '0;
            bs_q    <= 1'b0;
            ss_q    <= 1'b0;
            sw_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef FP_SPECIAL_DETECT_EN
            sp_q    <= 1'b0;
            nan_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            bm_q    <= bm_d;
            sm_q    <= sm_d;
            bs_q    <= bs_d;
            ss_q    <= ss_d;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
`ifdef FP_SPECIAL_DETECT_EN
            sp_q    <= sp_d;
            nan_q   <= nan_d;
`endif
        end
    end

    assign in_ready   = rst_n && (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign exp_out    = exp_q;
    assign big_mant   = bm_q;
    assign small_mant = sm_q;
    assign big_sign   = bs_q;
    assign small_sign = ss_q;
    assign eff_sub    = bs_q ^ ss_q;
    assign swapped    = sw_q;
`ifdef FP_SPECIAL_DETECT_EN
    assign special    = sp_q;
    assign is_nan     = nan_q;
`endif
endmodule

// File: tb/tb_fp_operand_align.sv
// Bench for fp_operand_align: two instances (1 and 4 bits/cycle) driven in lockstep,
// checked against an arithmetic alignment model.
module tb_fp_operand_align;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] src1 = '0, src2 = '0;

    logic        ir1, ov1, bs1, ss1, es1, sw1, ir4, ov4, bs4, ss4, es4, sw4;
    logic [7:0]  e1, e4;
    logic [26:0] bm1, sm1, bm4, sm4;
`ifdef FP_SPECIAL_DETECT_EN
    logic sp1, nn1, sp4, nn4;
`endif

    always #5 clk = ~clk;

    fp_operand_align #(.SHIFT_PER_CYCLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .src1(src1), .src2(src2), .out_valid(ov1), .out_ready(out_ready),
        .exp_out(e1), .big_mant(bm1), .small_mant(sm1), .big_sign(bs1),
        .small_sign(ss1), .eff_sub(es1),
`ifdef FP_SPECIAL_DETECT_EN
        .special(sp1), .is_nan(nn1),
`endif
        .swapped(sw1));

    fp_operand_align #(.SHIFT_PER_CYCLE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
        .src1(src1), .src2(src2), .out_valid(ov4), .out_ready(out_ready),
        .exp_out(e4), .big_mant(bm4), .small_mant(sm4), .big_sign(bs4),
        .small_sign(ss4), .eff_sub(es4),
`ifdef FP_SPECIAL_DETECT_EN
        .special(sp4), .is_nan(nn4),
`endif
        .swapped(sw4));

    int n_vec = 0, n_err = 0;
    logic [7:0]  cap_e;
    logic [26:0] cap_bm, cap_sm;
    logic        cap_sw, cap_es, cap_bs, cap_ss;

    typedef struct {
        logic [7:0]  e;
        logic [26:0] bm, sm;
        logic        bs, ss, sw, sp, nan;
        int          lat1, lat4;
    } ref_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Alignment computed directly: shift the whole mantissa, then OR in any lost bits
    function automatic ref_t model(input logic [31:0] a, input logic [31:0] b);
        ref_t r;
        logic [31:0] bg, sl;
        int eb, es, cnt;
        logic [63:0] mm;
        r.sw = (b[30:0] > a[30:0]);
        bg = r.sw ? b : a;
        sl = r.sw ? a : b;
        eb = (bg[30:23] == 8'd0) ? 1 : int'(bg[30:23]);
        es = (sl[30:23] == 8'd0) ? 1 : int'(sl[30:23]);
        cnt = eb - es;
        if (cnt > 27) cnt = 27;
        r.e  = 8'(eb);
        r.bm = {bg[30:23] != 8'd0, bg[22:0], 3'b000};
        mm   = {37'd0, sl[30:23] != 8'd0, sl[22:0], 3'b000};
        r.sm = 27'(mm >> cnt);
        if ((mm & ((64'd1 << cnt) - 64'd1)) != 64'd0) r.sm[0] = 1'b1;
        r.bs = bg[31];
        r.ss = sl[31];
        r.lat1 = cnt;
        r.lat4 = (cnt + 3) / 4;
        r.sp = 1'b0;
        r.nan = 1'b0;
`ifdef FP_SPECIAL_DETECT_EN
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            r.sp = 1'b1;
            r.sm = '0;
            r.lat1 = 0;
            r.lat4 = 0;
            r.nan = (a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)
                 || (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000 && a[31] != b[31]);
        end
`endif
        return r;
    endfunction

    task automatic chk_outs(input ref_t x);
        chk("u1.exp_out", e1, x.e);       chk("u4.exp_out", e4, x.e);
        chk("u1.big_mant", bm1, x.bm);    chk("u4.big_mant", bm4, x.bm);
        chk("u1.small_mant", sm1, x.sm);  chk("u4.small_mant", sm4, x.sm);
        chk("u1.big_sign", bs1, x.bs);    chk("u4.big_sign", bs4, x.bs);
        chk("u1.small_sign", ss1, x.ss);  chk("u4.small_sign", ss4, x.ss);
        chk("u1.eff_sub", es1, x.bs ^ x.ss);
        chk("u4.eff_sub", es4, x.bs ^ x.ss);
        chk("u1.swapped", sw1, x.sw);     chk("u4.swapped", sw4, x.sw);
`ifdef FP_SPECIAL_DETECT_EN
        chk("u1.special", sp1, x.sp);     chk("u4.special", sp4, x.sp);
        chk("u1.is_nan", nn1, x.nan);     chk("u4.is_nan", nn4, x.nan);
`endif
    endtask

    // One operation; hold keeps in_valid high while busy, stall holds off out_ready
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold, input int stall);
        ref_t x;
        int l1, l4;
        x = model(a, b);
        @(negedge clk);
        chk("u1.in_ready_idle", ir1, 1);
        chk("u4.in_ready_idle", ir4, 1);
        src1 = a; src2 = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        l1 = -1; l4 = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
            src1 = $urandom; src2 = $urandom;
            if (ov1 && l1 < 0) l1 = c;
            if (ov4 && l4 < 0) l4 = c;
            if (l1 >= 0 && l4 >= 0) break;
        end
        chk("u1.latency", l1, x.lat1);
        chk("u4.latency", l4, x.lat4);
        chk_outs(x);
        cap_e = e1; cap_bm = bm1; cap_sm = sm1; cap_sw = sw1;
        cap_es = es1; cap_bs = bs1; cap_ss = ss1;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            src1 = $urandom; src2 = $urandom; in_valid = 1'($urandom);
            chk("u1.out_valid_stall", ov1, 1);
            chk("u1.in_ready_stall", ir1, 0);
            chk("u4.in_ready_stall", ir4, 0);
            chk_outs(x);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("u1.out_valid_drop", ov1, 0);
        chk("u4.out_valid_drop", ov4, 0);
        chk("u1.in_ready_back", ir1, 1);
        chk("u4.in_ready_back", ir4, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int ea, eb;
        repeat (2) @(negedge clk);
        chk("rst.in_ready", ir1, 0);  chk("rst.out_valid", ov1, 0);
        chk("rst.exp_out", e1, 0);    chk("rst.small_mant", sm1, 0);
        chk("rst.big_mant", bm4, 0);  chk("rst.swapped", sw4, 0);
        rst_n = 1'b1;

        do_op(32'h40400000, 32'h3F800000, 1'b0, 0);
        chk("basic.exp_out", cap_e, 8'h80);
        chk("basic.big_mant", cap_bm, 27'h6000000);
        chk("basic.small_mant", cap_sm, 27'h2000000);
        chk("basic.swapped", cap_sw, 0);

        do_op(32'h3F800000, 32'hC0400000, 1'b0, 0);
        chk("swap.swapped", cap_sw, 1);
        chk("swap.eff_sub", cap_es, 1);
        chk("swap.big_sign", cap_bs, 1);
        chk("swap.small_sign", cap_ss, 0);

        do_op(32'h4B800000, 32'h3C800001, 1'b1, 0);
        chk("clamp.small_mant", cap_sm, 27'h0000001);
        chk("clamp.exp_out", cap_e, 8'h97);

        do_op(32'h3F800000, 32'h3F800000, 1'b1, 5);
        chk("bp.swapped", cap_sw, 0);

        // Reset part-way through a long shift
        @(negedge clk);
        src1 = 32'h4B800000; src2 = 32'h3C800001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.u1.out_valid", ov1, 0);  chk("midrst.u4.out_valid", ov4, 0);
        chk("midrst.u1.in_ready", ir1, 0);   chk("midrst.u1.small_mant", sm1, 0);
        chk("midrst.u1.exp_out", e1, 0);     chk("midrst.u1.big_mant", bm1, 0);
        chk("midrst.u4.small_mant", sm4, 0); chk("midrst.u1.swapped", sw1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.u1.out_valid_after", ov1, 0);
        do_op(32'hBF000000, 32'h41200000, 1'b0, 0);

        do_op(32'h7F800000, 32'h3F800000, 1'b0, 0);
        do_op(32'h7F800000, 32'hFF800000, 1'b0, 0);
        do_op(32'h7FC00001, 32'h00000001, 1'b0, 0);
        do_op(32'h00000000, 32'h80000000, 1'b0, 0);
        do_op(32'h00000003, 32'h00800000, 1'b0, 0);
        do_op(32'h3F800000, 32'h00000000, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            ea = int'(a[30:23]);
            eb = ea - int'($urandom_range(0, 32));
            if (eb < 0) eb = 0;
            b  = {1'($urandom), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 7) == 0) b[30:0] = '0;
            if ($urandom_range(0, 1) == 1) do_op(b, a, 1'($urandom), int'($urandom_range(0, 2)));
            else                           do_op(a, b, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
